// File: rtl/jk_excite_drv.sv
// Excitation driver for a JK-style flop: turns one requested target bit per handshake
// into a registered J/K pulse, verifies the flop output and retries before flagging an error.
module jk_excite_drv #(
    parameter logic        DC_VAL    = 1'b0,
    parameter int unsigned RETRY_MAX = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             y_fb,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10,
        ERR   = 2'b11
    } state_e;

    localparam logic [2:0] RETRY_LIM = 3'(RETRY_MAX);

    state_e           state_q, state_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic [2:0]       retry_q, retry_d;
    logic             tgt_q, tgt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // {j, k} needed to move the flop from q to d; the unconstrained pin gets DC_VAL.
    function automatic logic [1:0] excite(input logic q, input logic d);
        return q ? {DC_VAL, ~d} : {d, DC_VAL};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            retry_q   <= '0;
            tgt_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            retry_q   <= retry_d;
            tgt_q     <= tgt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        j_d       = 1'b0;
        k_d       = 1'b0;
        retry_d   = retry_q;
        tgt_d     = tgt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d      = tgt_bit;
                    {j_d, k_d} = excite(y_fb, tgt_bit);
                    retry_d    = '0;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (y_fb == tgt_q) begin
                    state_d = IDLE;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d    = retry_q + 3'd1;
                    {j_d, k_d} = excite(y_fb, tgt_q);
                    state_d    = DRIVE;
                end else begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // done must reflect the flop output observed during CHECK, so it is decoded, not registered.
    assign done      = (state_q == CHECK) && (y_fb == tgt_q);
    assign mismatch  = (state_q == ERR);
    assign busy      = (state_q != IDLE);
    assign tgt_ready = (state_q == IDLE) && !reset;
    assign j         = j_q;
    assign k         = k_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jk_excite_drv.sv
// Bench for jk_excite_drv: a behavioural JK flop (with a stuck-output option) closes the loop,
// and each transaction's cycle-by-cycle outputs are predicted from the excitation/retry rules.
module tb_jk_excite_drv;

    localparam logic        DCV  = 1'b1;
    localparam int unsigned RMAX = 2;
    localparam int unsigned CW   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tgt_valid = 1'b0;
    logic          tgt_bit = 1'b0;
    logic          y_fb;
    logic          tgt_ready, j, k, busy, done, mismatch;
    logic [CW-1:0] err_cnt;

    logic          v1 = 1'b0, b1 = 1'b0, y1 = 1'b0;
    logic          r1, j1, k1, busy1, done1, mm1;
    logic [7:0]    ec1;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    logic y_m = 1'b0;
    logic y_load = 1'b0, y_load_val = 1'b0;
    logic stuck = 1'b0;
    logic cur_d = 1'b0;

    always #5 clk = ~clk;

    // Behavioural JK flop; when stuck it refuses to reach the requested target.
    always @(posedge clk) begin
        if (y_load)     y_m <= y_load_val;
        else if (stuck) y_m <= ~cur_d;
        else            y_m <= (j & ~y_m) | (~k & y_m);
    end
    assign y_fb = y_m;

    jk_excite_drv #(.DC_VAL(DCV), .RETRY_MAX(RMAX), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready), .y_fb(y_fb), .j(j), .k(k), .busy(busy),
        .done(done), .mismatch(mismatch), .err_cnt(err_cnt)
    );

    jk_excite_drv #(.DC_VAL(1'b0), .RETRY_MAX(0), .CNT_W(8)) u_dut_r0 (
        .clk(clk), .reset(reset), .tgt_valid(v1), .tgt_bit(b1),
        .tgt_ready(r1), .y_fb(y1), .j(j1), .k(k1), .busy(busy1),
        .done(done1), .mismatch(mm1), .err_cnt(ec1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [1:0] exp_jk(input logic q, input logic d);
        case ({q, d})
            2'b00:   return {1'b0, DCV};
            2'b01:   return {1'b1, DCV};
            2'b10:   return {DCV, 1'b1};
            default: return {DCV, 1'b0};
        endcase
    endfunction

    task automatic load_y(input logic v);
        y_load = 1'b1;
        y_load_val = v;
        tick();
        y_load = 1'b0;
    endtask

    // fail_n = number of CHECK cycles in which the flop is held off its target.
    task automatic run_txn(input logic d, input int fail_n, input logic noisy);
        logic       q;
        logic [1:0] jk;
        q = y_m;
        chk("idle_ready", tgt_ready, 1);
        chk("idle_busy", busy, 0);
        cur_d = d;
        tgt_valid = 1'b1;
        tgt_bit = d;
        tick();
        if (noisy) begin
            tgt_valid = 1'($urandom_range(0, 1));
            tgt_bit = 1'($urandom_range(0, 1));
        end else begin
            tgt_valid = 1'b0;
        end
        for (int a = 0; a <= int'(RMAX); a++) begin
            jk = exp_jk(q, d);
            chk("drv_j", j, jk[1]);
            chk("drv_k", k, jk[0]);
            chk("drv_busy", busy, 1);
            chk("drv_ready", tgt_ready, 0);
            chk("drv_done", done, 0);
            stuck = (a < fail_n);
            tick();
            chk("chk_j", j, 0);
            chk("chk_k", k, 0);
            chk("chk_busy", busy, 1);
            chk("chk_ready", tgt_ready, 0);
            if (!stuck) begin
                chk("chk_done", done, 1);
                chk("chk_y", y_fb, d);
                tick();
                break;
            end
            chk("chk_nodone", done, 0);
            q = ~d;
            if (a == int'(RMAX)) begin
                tick();
                chk("err_mismatch", mismatch, 1);
                chk("err_busy", busy, 1);
                chk("err_done", done, 0);
                exp_cnt = (exp_cnt == (1 << CW) - 1) ? exp_cnt : exp_cnt + 1;
                tick();
                break;
            end
            tick();
        end
        stuck = 1'b0;
        tgt_valid = 1'b0;
        chk("end_ready", tgt_ready, 1);
        chk("end_mismatch", mismatch, 0);
        chk("end_done", done, 0);
        chk("err_cnt", err_cnt, exp_cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic bits [3];
        int   hs, dn, last_rdy;
        logic d;

        @(negedge clk);
        chk("rst_ready", tgt_ready, 0);
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_done", done, 0);
        tick();
        reset = 1'b0;
        load_y(1'b0);

        run_txn(1'b1, 0, 1'b0);
        run_txn(1'b0, 0, 1'b0);
        run_txn(1'b1, 0, 1'b0);
        run_txn(1'b1, 0, 1'b0);

        load_y(1'b0);
        run_txn(1'b1, 3, 1'b0);
        for (int n = 0; n < 3; n++) run_txn(1'(n & 1), 3, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) load_y(1'($urandom_range(0, 1)));
            run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);
        end

        load_y(1'b0);
        tgt_valid = 1'b1;
        tgt_bit = 1'b1;
        tick();
        tgt_valid = 1'b0;
        chk("abort_j_before", j, 1);
        reset = 1'b1;
        #1;
        chk("abort_j", j, 0);
        chk("abort_k", k, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", tgt_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_mismatch", mismatch, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            chk("post_abort_done", done | mismatch | busy, 0);
            tick();
        end
        chk("post_abort_cnt", err_cnt, 0);
        run_txn(1'b1, 0, 1'b0);
        for (int n = 0; n < 10; n++) begin
            d = 1'($urandom_range(0, 1));
            run_txn(d, int'($urandom_range(0, 3)), 1'b1);
        end

        bits[0] = 1'b1;
        bits[1] = 1'b0;
        bits[2] = 1'b1;
        hs = 0;
        dn = 0;
        last_rdy = -1;
        tgt_valid = 1'b1;
        tgt_bit = bits[0];
        for (int c = 0; c < 20 && dn < 3; c++) begin
            if (done) begin
                chk("b2b_y", y_fb, bits[dn]);
                dn++;
            end
            if (tgt_ready) begin
                if (hs < 3) begin
                    if (last_rdy >= 0) chk("b2b_gap", c - last_rdy, 3);
                    last_rdy = c;
                    tgt_bit = bits[hs];
                    hs++;
                end else begin
                    tgt_valid = 1'b0;
                end
            end
            tick();
        end
        tgt_valid = 1'b0;
        chk("b2b_dones", dn, 3);
        chk("b2b_hs", hs, 3);

        y1 = 1'b0;
        v1 = 1'b1;
        b1 = 1'b1;
        chk("r0_ready", r1, 1);
        tick();
        v1 = 1'b0;
        chk("r0_j", j1, 1);
        chk("r0_k", k1, 0);
        tick();
        chk("r0_chk", {done1, mm1, busy1}, 3'b001);
        tick();
        chk("r0_err", {done1, mm1, busy1}, 3'b011);
        tick();
        chk("r0_cnt", ec1, 1);
        chk("r0_idle", {r1, busy1}, 2'b10);
        y1 = 1'b1;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        chk("r0_hold_jk", {j1, k1}, 2'b00);
        tick();
        chk("r0_done", done1, 1);
        tick();
        chk("r0_cnt_keep", ec1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
